tl_mmio_acquire_bridge: RTL

Converts a simple single-beat MMIO request/response interface into uncached TileLink Acquire/Grant transactions for the PRCI timer/IPI slave. It sits directly upstream of the PRCI TileLink port: it drives `acquire` and consumes `grant`. It tracks up to four outstanding transactions with 2-bit `client_xact_id` tags and returns responses in issue order.

---
 rtl/tl_mmio_pkg.sv | 36 +++
 rtl/tl_resp_fifo.sv | 57 +++++
 rtl/tl_mmio_acquire_bridge.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tl_mmio_pkg.sv
// Shared TileLink MMIO constants, Acquire payload struct and union encoder
// used by the MMIO-to-TileLink acquire bridge.
package tl_mmio_pkg;

    localparam logic [2:0] A_GET      = 3'h0;
    localparam logic [2:0] A_PUT      = 3'h2;
    localparam logic [3:0] G_GET_DATA = 4'h4;
    localparam logic [3:0] G_PUT_ACK  = 4'h3;
    localparam logic [2:0] MT_D       = 3'b011;

    localparam int ADDR_BLOCK_W = 26;
    localparam int ADDR_BEAT_W  = 3;
    localparam int UNION_W      = 12;

    typedef struct packed {
        logic [ADDR_BLOCK_W-1:0] addr_block;
        logic [ADDR_BEAT_W-1:0]  addr_beat;
        logic [1:0]              xact_id;
        logic [2:0]              a_type;
        logic [UNION_W-1:0]      a_union;
        logic [63:0]             data;
    } acq_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } resp_t;

    // Get carries the byte offset and a doubleword operand size; Put carries the byte mask.
    function automatic logic [UNION_W-1:0] acq_union_enc(input logic       is_write,
                                                         input logic [2:0] byte_off,
                                                         input logic [7:0] wstrb);
        return is_write ? {3'b000, wstrb, 1'b1} : {byte_off, MT_D, 5'b00000, 1'b1};
    endfunction

endpackage

// File: rtl/tl_resp_fifo.sv
// Two-entry synchronous FIFO for bridge responses. The full flag is a flop, so a
// pop in the same cycle as a full FIFO does not open a slot until the next cycle.
module tl_resp_fifo #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic         full_o,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_q, wr_d, rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              do_push, do_pop;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        do_push = push_i && !full_q;
        do_pop  = pop_i && (cnt_q != 2'd0);
        if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = ~wr_q;
        end
        if (do_pop) rd_d = ~rd_q;
        cnt_d  = cnt_q + 2'(do_push) - 2'(do_pop);
        full_d = (cnt_d == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= 2'd0;
            full_q <= 1'b0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    assign full_o  = full_q;
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_q];

endmodule

// File: rtl/tl_mmio_acquire_bridge.sv
// Single-beat MMIO request/response to uncached TileLink Acquire/Grant bridge with
// up to four in-order outstanding transactions tagged by a 2-bit client_xact_id.
module tl_mmio_acquire_bridge
    import tl_mmio_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [31:0]             req_addr,
    input  logic                    req_write,
    input  logic [63:0]             req_wdata,
    input  logic [7:0]              req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [63:0]             resp_rdata,
    output logic                    resp_err,
    output logic                    acq_valid,
    input  logic                    acq_ready,
    output logic [ADDR_BLOCK_W-1:0] acq_addr_block,
    output logic [ADDR_BEAT_W-1:0]  acq_addr_beat,
    output logic [1:0]              acq_client_xact_id,
    output logic                    acq_is_builtin_type,
    output logic [2:0]              acq_a_type,
    output logic [UNION_W-1:0]      acq_union,
    output logic [63:0]             acq_data,
    input  logic                    gnt_valid,
    output logic                    gnt_ready,
    input  logic [1:0]              gnt_client_xact_id,
    input  logic [3:0]              gnt_g_type,
    input  logic [63:0]             gnt_data
);

    logic       acq_valid_q, acq_valid_d;
    acq_t       acq_q, acq_d;
    logic [1:0] issue_ptr_q, issue_ptr_d;
    logic [1:0] expect_ptr_q, expect_ptr_d;
    logic [2:0] outstanding_q, outstanding_d;
    logic [3:0] sb_q, sb_d;
    logic       orphan_q, orphan_d;

    logic       req_fire, acq_fire, gnt_fire, gnt_ok, orphan, exp_write, fifo_full;
    logic [3:0] inflight, exp_type;
    resp_t      push_data, pop_data;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        acq_fire  = acq_valid_q && acq_ready;
        gnt_fire  = gnt_valid && !fifo_full;
        // A pending Acquire in the output register already holds a credit.
        inflight  = {1'b0, outstanding_q} + {3'b000, acq_valid_q};
        req_ready = (!acq_valid_q || acq_ready) && (inflight < 4'(MAX_OUTSTANDING));
        req_fire  = req_valid && req_ready;
        orphan    = gnt_fire && (outstanding_q == 3'd0);
        gnt_ok    = gnt_fire && !orphan;
        exp_write = sb_q[expect_ptr_q];
        exp_type  = exp_write ? G_PUT_ACK : G_GET_DATA;

        push_data.rdata = exp_write ? 64'd0 : gnt_data;
        push_data.err   = (gnt_client_xact_id != expect_ptr_q) || (gnt_g_type != exp_type) || orphan_q;

        acq_valid_d   = acq_valid_q;
        acq_d         = acq_q;
        issue_ptr_d   = issue_ptr_q;
        expect_ptr_d  = expect_ptr_q;
        outstanding_d = outstanding_q;
        sb_d          = sb_q;
        orphan_d      = orphan_q;

        if (req_fire) begin
            acq_valid_d        = 1'b1;
            acq_d.addr_block   = req_addr[31:6];
            acq_d.addr_beat    = req_addr[5:3];
            acq_d.xact_id      = issue_ptr_q;
            acq_d.a_type       = req_write ? A_PUT : A_GET;
            acq_d.a_union      = acq_union_enc(req_write, req_addr[2:0], req_wstrb);
            acq_d.data         = req_wdata;
            sb_d[issue_ptr_q]  = req_write;
            issue_ptr_d        = ptr_inc(issue_ptr_q);
        end else if (acq_fire) begin
            acq_valid_d = 1'b0;
        end

        if (gnt_ok) expect_ptr_d = ptr_inc(expect_ptr_q);

        case ({acq_fire, gnt_ok})
            2'b10:   outstanding_d = outstanding_q + 3'd1;
            2'b01:   outstanding_d = outstanding_q - 3'd1;
            default: outstanding_d = outstanding_q;
        endcase

        // An orphan Grant is swallowed; its error is reported on the next real response.
        if (orphan)      orphan_d = 1'b1;
        else if (gnt_ok) orphan_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acq_valid_q   <= 1'b0;
            issue_ptr_q   <= 2'd0;
            expect_ptr_q  <= 2'd0;
            outstanding_q <= 3'd0;
            sb_q          <= 4'd0;
            orphan_q      <= 1'b0;
        end else begin
            acq_valid_q   <= acq_valid_d;
            issue_ptr_q   <= issue_ptr_d;
            expect_ptr_q  <= expect_ptr_d;
            outstanding_q <= outstanding_d;
            sb_q          <= sb_d;
            orphan_q      <= orphan_d;
        end
    end

    always_ff @(posedge clk) acq_q <= acq_d;

    tl_resp_fifo #(.W($bits(resp_t))) u_resp_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (gnt_ok),
        .data_i  (push_data),
        .full_o  (fifo_full),
        .pop_i   (resp_ready),
        .data_o  (pop_data),
        .valid_o (resp_valid)
    );

    assign gnt_ready           = !fifo_full;
    assign resp_rdata          = pop_data.rdata;
    assign resp_err            = resp_valid && pop_data.err;
    assign acq_valid           = acq_valid_q;
    assign acq_addr_block      = acq_q.addr_block;
    assign acq_addr_beat       = acq_q.addr_beat;
    assign acq_client_xact_id  = acq_q.xact_id;
    assign acq_is_builtin_type = 1'b1;
    assign acq_a_type          = acq_q.a_type;
    assign acq_union           = acq_q.a_union;
    assign acq_data            = acq_q.data;

endmodule
